// File: rtl/decrypt_pkg.sv
// Shared types and arithmetic for the receive-side decrypt datapath.
// Holds the FSM encoding plus the expansion box and 4-bit carry-select adder.
package decrypt_pkg;

  localparam int DATA_W = 8;
  localparam int NIB_W  = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXP  = 2'd1;
  localparam logic [1:0] ST_ADD  = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  function automatic logic [DATA_W-1:0] expand(input logic [NIB_W-1:0] l);
    return {l[3], l[0], l[1], l[2], l[1], l[3], l[2], l[0]};
  endfunction

  // Low pair ripples; high pair is precomputed for both carries and selected.
  function automatic logic [NIB_W-1:0] csa4(input logic [NIB_W-1:0] a,
                                            input logic [NIB_W-1:0] b,
                                            input logic             cin);
    logic [2:0] lo;
    logic [1:0] hi0;
    logic [1:0] hi1;
    lo  = {1'b0, a[1:0]} + {1'b0, b[1:0]} + {2'b00, cin};
    hi0 = a[3:2] + b[3:2];
    hi1 = a[3:2] + b[3:2] + 2'd1;
    return {(lo[2] ? hi1 : hi0), lo[1:0]};
  endfunction

endpackage

// File: rtl/decrypt_out_fifo.sv
// Synchronous output FIFO, DEPTH x WIDTH; read data is zero when empty, no bypass.
// Push is dropped when full and pop when empty; full is judged before any same-cycle pop.
module decrypt_out_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/decrypt_unit.sv
// Recovers plaintext from ciphertext+key: 3-cycle latency, one word per 4 cycles, in_ready only in IDLE.
// A full output FIFO stalls the FSM in WR; DECRYPT_CHECK_EN adds a re-encrypt self-check flagged on dec_err.
module decrypt_unit
  import decrypt_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] enc_in,
  input  logic [7:0] key_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] dec_out,
  output logic       dec_err
);

`ifdef DECRYPT_CHECK_EN
  localparam int FIFO_W = DATA_W + 1;
`else
  localparam int FIFO_W = DATA_W;
`endif

  logic [1:0]        state;
  logic [DATA_W-1:0] enc_q;
  logic [DATA_W-1:0] key_q;
  logic [DATA_W-1:0] x_q;
  logic [NIB_W-1:0]  f_q;
  logic [DATA_W-1:0] plain;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic [FIFO_W-1:0] push_dat;
  logic [FIFO_W-1:0] pop_dat;

  assign in_ready  = (state == ST_IDLE) & reset;
  assign out_valid = ~fifo_empty;
  assign fifo_push = (state == ST_WR) & ~fifo_full;
  assign plain     = {enc_q[7:4] ^ f_q, enc_q[3:0]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      enc_q <= '0;
      key_q <= '0;
      x_q   <= '0;
      f_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (in_valid) begin
          enc_q <= enc_in;
          key_q <= key_in;
          state <= ST_EXP;
        end
        ST_EXP: begin
          x_q   <= expand(enc_q[3:0]) ^ key_q;
          state <= ST_ADD;
        end
        ST_ADD: begin
          f_q   <= csa4(x_q[7:4], x_q[3:0], key_q[0]);
          state <= ST_WR;
        end
        default: if (!fifo_full) state <= ST_IDLE;
      endcase
    end
  end

`ifdef DECRYPT_CHECK_EN
  logic [DATA_W-1:0] chk_x;
  logic [NIB_W-1:0]  chk_f;
  logic              chk_err;

  // Re-encrypt the recovered word; any difference from the stored ciphertext is a datapath fault.
  always_comb begin
    chk_x   = expand(plain[3:0]) ^ key_q;
    chk_f   = csa4(chk_x[7:4], chk_x[3:0], key_q[0]);
    chk_err = ({plain[7:4] ^ chk_f, plain[3:0]} != enc_q);
  end

  assign push_dat = {chk_err, plain};
  assign dec_out  = pop_dat[DATA_W-1:0];
  assign dec_err  = pop_dat[DATA_W];
`else
  assign push_dat = plain;
  assign dec_out  = pop_dat;
  assign dec_err  = 1'b0;
`endif

  decrypt_out_fifo #(
    .DEPTH(OUT_DEPTH),
    .WIDTH(FIFO_W)
  ) u_out_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (out_valid & out_ready),
    .pop_dat  (pop_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
